// File: rtl/rgmii_pkg.sv
// Shared RGMII TX definitions: speed codes, default TXC dividers, CTL encoding.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam int DIV_100_DEF = 5;
    localparam int DIV_10_DEF  = 50;

    // RGMII carries tx_en on the rising half and tx_en^tx_er on the falling half
    function automatic logic [1:0] ctl_encode(input logic en, input logic er);
        return {en, en ^ er};
    endfunction

endpackage

// File: rtl/rgmii_txc_gen.sv
// TXC pattern/timing generator: divider counter, d1/d2 clock pattern, load and MAC enable strobes.
// Latency: registered outputs one clk after the counter state; load/resync are combinational strobes.
// Backpressure: none; the MAC is paced through tx_clk_en only.
module rgmii_txc_gen
    import rgmii_pkg::*;
#(
    parameter int DIV_100 = DIV_100_DEF,
    parameter int DIV_10  = DIV_10_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    output logic       gig_mode,
    output logic       resync,
    output logic       load,
    output logic       phase,
    output logic       mii_select,
    output logic       tx_clk_en,
    output logic       txc_d1,
    output logic       txc_d2
);

    localparam int CW = $clog2(DIV_10);

    localparam logic [CW-1:0] LAST_100  = CW'(DIV_100 - 1);
    localparam logic [CW-1:0] LAST_10   = CW'(DIV_10 - 1);
    localparam logic [CW-1:0] LOAD_100  = CW'(DIV_100 / 2 + 1);
    localparam logic [CW-1:0] LOAD_10   = CW'(DIV_10 / 2 + 1);
    localparam logic [CW-1:0] PRE_100   = CW'(DIV_100 / 2 - 1);
    localparam logic [CW-1:0] PRE_10    = CW'(DIV_10 / 2 - 1);
    localparam logic [CW-1:0] HIGH1_100 = CW'((DIV_100 + 1) / 2);
    localparam logic [CW-1:0] HIGH2_100 = CW'(DIV_100 / 2);
    localparam logic [CW-1:0] HALF_10   = CW'(DIV_10 / 2);

    logic [1:0]    speed_reg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_cnt;
    logic [CW-1:0] load_cnt;
    logic [CW-1:0] pre_cnt;
    logic          is_100;

    always_comb begin
        gig_mode = speed_reg[1];
        is_100   = (speed_reg == SPEED_100);
        last_cnt = is_100 ? LAST_100 : LAST_10;
        load_cnt = is_100 ? LOAD_100 : LOAD_10;
        pre_cnt  = is_100 ? PRE_100  : PRE_10;
        resync   = (speed != speed_reg);
        // Load lands just after TXC falls so data is settled by the next rising edge
        load     = !gig_mode && !resync && (cnt == load_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_reg  <= SPEED_1000;
            cnt        <= '0;
            phase      <= 1'b0;
            mii_select <= 1'b0;
            tx_clk_en  <= 1'b0;
            txc_d1     <= 1'b0;
            txc_d2     <= 1'b0;
        end else if (resync) begin
            speed_reg  <= speed;
            cnt        <= '0;
            phase      <= 1'b0;
            mii_select <= !speed[1];
            tx_clk_en  <= 1'b0;
            txc_d1     <= 1'b0;
            txc_d2     <= 1'b0;
        end else if (gig_mode) begin
            cnt        <= '0;
            phase      <= 1'b0;
            mii_select <= 1'b0;
            tx_clk_en  <= 1'b1;
            txc_d1     <= 1'b1;
            txc_d2     <= 1'b0;
        end else begin
            cnt        <= (cnt == last_cnt) ? '0 : cnt + CW'(1);
            mii_select <= 1'b1;
            if (load)
                phase <= ~phase;
            // MAC steps its byte one cycle ahead of the low-nibble load
            tx_clk_en  <= (cnt == pre_cnt) && !phase;
            if (is_100) begin
                txc_d1 <= (cnt < HIGH1_100);
                txc_d2 <= (cnt < HIGH2_100);
            end else begin
                txc_d1 <= (cnt < HALF_10);
                txc_d2 <= (cnt < HALF_10);
            end
        end
    end

endmodule

// File: rtl/rgmii_tx_ddr_gen.sv
// GMII-to-RGMII TX prep: per-cycle d1/d2 values for TXD, TX_CTL and forwarded TXC at 10/100/1000.
// Latency: 1 clk at 1000M; at 10/100 nibbles appear at the load point after the MAC enable pulse.
// Backpressure: MAC advances only on tx_clk_en; a speed change drops any half-sent byte.
module rgmii_tx_ddr_gen
    import rgmii_pkg::*;
#(
    parameter int DIV_100 = DIV_100_DEF,
    parameter int DIV_10  = DIV_10_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] mac_gmii_txd,
    input  logic       mac_gmii_tx_en,
    input  logic       mac_gmii_tx_er,
    output logic       mac_gmii_tx_clk_en,
    output logic       mii_select,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       txctl_d1,
    output logic       txctl_d2,
    output logic       txc_d1,
    output logic       txc_d2
);

    logic       gig_mode;
    logic       resync;
    logic       load;
    logic       phase;
    logic [3:0] hold_hi;
    logic [1:0] hold_ctl;

    rgmii_txc_gen #(
        .DIV_100 (DIV_100),
        .DIV_10  (DIV_10)
    ) u_txc_gen (
        .clk        (clk),
        .rst        (rst),
        .speed      (speed),
        .gig_mode   (gig_mode),
        .resync     (resync),
        .load       (load),
        .phase      (phase),
        .mii_select (mii_select),
        .tx_clk_en  (mac_gmii_tx_clk_en),
        .txc_d1     (txc_d1),
        .txc_d2     (txc_d2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_d1   <= '0;
            txd_d2   <= '0;
            txctl_d1 <= 1'b0;
            txctl_d2 <= 1'b0;
            hold_hi  <= '0;
            hold_ctl <= '0;
        end else if (resync) begin
            txd_d1   <= '0;
            txd_d2   <= '0;
            txctl_d1 <= 1'b0;
            txctl_d2 <= 1'b0;
        end else if (gig_mode) begin
            txd_d1               <= mac_gmii_txd[3:0];
            txd_d2               <= mac_gmii_txd[7:4];
            {txctl_d1, txctl_d2} <= ctl_encode(mac_gmii_tx_en, mac_gmii_tx_er);
        end else if (load) begin
            if (!phase) begin
                // The whole byte is captured here; the high nibble follows one TXC period later
                hold_hi              <= mac_gmii_txd[7:4];
                hold_ctl             <= ctl_encode(mac_gmii_tx_en, mac_gmii_tx_er);
                txd_d1               <= mac_gmii_txd[3:0];
                txd_d2               <= mac_gmii_txd[3:0];
                {txctl_d1, txctl_d2} <= ctl_encode(mac_gmii_tx_en, mac_gmii_tx_er);
            end else begin
                txd_d1               <= hold_hi;
                txd_d2               <= hold_hi;
                {txctl_d1, txctl_d2} <= hold_ctl;
            end
        end
    end

endmodule

// File: tb/tb_rgmii_tx_ddr_gen.sv
// Bench for rgmii_tx_ddr_gen: gigabit vector table, directed 10/100/resync/reset sequences,
// and randomized traffic against a cycle-count reference model.
module tb_rgmii_tx_ddr_gen;

    localparam int DIV_100 = 5;
    localparam int DIV_10  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'b10;
    logic [7:0] txd = 8'h00;
    logic       en = 1'b0;
    logic       er = 1'b0;

    logic       mac_gmii_tx_clk_en;
    logic       mii_select;
    logic [3:0] txd_d1, txd_d2;
    logic       txctl_d1, txctl_d2, txc_d1, txc_d2;

    rgmii_tx_ddr_gen #(.DIV_100(DIV_100), .DIV_10(DIV_10)) dut (
        .clk                (clk),
        .rst                (rst),
        .speed              (speed),
        .mac_gmii_txd       (txd),
        .mac_gmii_tx_en     (en),
        .mac_gmii_tx_er     (er),
        .mac_gmii_tx_clk_en (mac_gmii_tx_clk_en),
        .mii_select         (mii_select),
        .txd_d1             (txd_d1),
        .txd_d2             (txd_d2),
        .txctl_d1           (txctl_d1),
        .txctl_d2           (txctl_d2),
        .txc_d1             (txc_d1),
        .txc_d2             (txc_d2)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model state
    logic [1:0] m_speed;
    int         m_k;
    int         m_loads;
    logic [3:0] m_hi;
    logic [1:0] m_ctl;
    logic       e_clken, e_mii, e_c1, e_c2, e_t1, e_t2;
    logic [3:0] e_d1, e_d2;

    logic [13:0] dut_vec;
    logic [13:0] m_vec;
    assign dut_vec = {mac_gmii_tx_clk_en, mii_select, txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2};
    assign m_vec   = {e_clken, e_mii, e_d1, e_d2, e_c1, e_c2, e_t1, e_t2};

    typedef struct {
        logic [7:0] d;
        logic       en;
        logic       er;
        logic [3:0] x1;
        logic [3:0] x2;
        logic       c1;
        logic       c2;
    } vec_t;

    vec_t       vecs [6];
    logic [1:0] pat100 [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic model_reset();
        m_speed = 2'b10;
        m_k     = 0;
        m_loads = 0;
        m_hi    = 4'h0;
        m_ctl   = 2'b00;
        {e_clken, e_mii, e_d1, e_d2, e_c1, e_c2, e_t1, e_t2} = 14'h0;
    endtask

    // Model in terms of elapsed cycles k since the mode started: TXC spans 2*div
    // half-cycles with the first div high; a load every div cycles alternates low/high nibble.
    task automatic model_step(input logic [1:0] sp, input logic [7:0] d, input logic ie, input logic ir);
        int div;
        int t;
        if (sp != m_speed) begin
            m_speed = sp;
            m_k     = 0;
            m_loads = 0;
            {e_clken, e_d1, e_d2, e_c1, e_c2, e_t1, e_t2} = 13'h0;
            e_mii   = !sp[1];
        end else if (sp[1]) begin
            e_clken = 1'b1;
            e_mii   = 1'b0;
            e_d1    = d[3:0];
            e_d2    = d[7:4];
            e_c1    = ie;
            e_c2    = ie ^ ir;
            e_t1    = 1'b1;
            e_t2    = 1'b0;
        end else begin
            div     = (sp == 2'b01) ? DIV_100 : DIV_10;
            t       = m_k % div;
            e_mii   = 1'b1;
            e_t1    = (2 * t) < div;
            e_t2    = (2 * t + 1) < div;
            e_clken = (t == div / 2 - 1) && (m_loads % 2 == 0);
            if (t == div / 2 + 1) begin
                if (m_loads % 2 == 0) begin
                    m_hi  = d[7:4];
                    m_ctl = {ie, ie ^ ir};
                    e_d1  = d[3:0];
                    e_d2  = d[3:0];
                end else begin
                    e_d1  = m_hi;
                    e_d2  = m_hi;
                end
                {e_c1, e_c2} = m_ctl;
                m_loads++;
            end
            m_k++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(speed, txd, en, er);
        #1;
        check("model", 32'(dut_vec), 32'(m_vec));
    endtask

    initial begin
        int         pulses;
        logic [31:0] r;
        int         n;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 4'h5, 4'hA, 1'b1, 1'b1};
        vecs[1] = '{8'h5A, 1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 4'hC, 4'h3, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1};
        vecs[5] = '{8'h12, 1'b0, 1'b0, 4'h2, 4'h1, 1'b0, 1'b0};
        pat100[0] = 2'b11;
        pat100[1] = 2'b11;
        pat100[2] = 2'b10;
        pat100[3] = 2'b00;
        pat100[4] = 2'b00;

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_vec", 32'(dut_vec), 32'h0);
        #2 rst = 1'b0;

        // Gigabit vector table
        for (int i = 0; i < 6; i++) begin
            txd = vecs[i].d;
            en  = vecs[i].en;
            er  = vecs[i].er;
            tick();
            check("g_txd_d1", 32'(txd_d1), 32'(vecs[i].x1));
            check("g_txd_d2", 32'(txd_d2), 32'(vecs[i].x2));
            check("g_ctl", 32'({txctl_d1, txctl_d2}), 32'({vecs[i].c1, vecs[i].c2}));
            check("g_txc", 32'({txc_d1, txc_d2}), 32'(2'b10));
            check("g_clken", 32'(mac_gmii_tx_clk_en), 32'h1);
        end

        // 100M: TXC pattern, enable rate, SDR nibbles of 8'h3C
        txd = 8'h3C; en = 1'b1; er = 1'b0; speed = 2'b01;
        tick();
        check("r100_mii", 32'(mii_select), 32'h1);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (mac_gmii_tx_clk_en) pulses++;
            if (i <= 5)
                check("t100_txc", 32'({txc_d1, txc_d2}), 32'(pat100[i-1]));
            if (i == 2)
                check("t100_clken_pos", 32'(mac_gmii_tx_clk_en), 32'h1);
            if (i >= 4 && i <= 13) begin
                check("t100_d1", 32'(txd_d1), (i < 9) ? 32'hC : 32'h3);
                check("t100_d2", 32'(txd_d2), (i < 9) ? 32'hC : 32'h3);
            end
        end
        check("t100_pulses", 32'(pulses), 32'd2);

        // Switch to 1000M right after a low-nibble load
        repeat (4) tick();
        check("sw_lo_loaded", 32'(txd_d1), 32'hC);
        speed = 2'b10; txd = 8'h7E;
        tick();
        check("sw_resync_ctl", 32'({txctl_d1, txctl_d2}), 32'h0);
        check("sw_resync_clken", 32'(mac_gmii_tx_clk_en), 32'h0);
        check("sw_resync_txd", 32'({txd_d1, txd_d2}), 32'h0);
        tick();
        check("sw_gig_txd", 32'({txd_d1, txd_d2}), 32'hE7);
        check("sw_gig_txc", 32'({txc_d1, txc_d2}), 32'(2'b10));
        check("sw_gig_clken", 32'(mac_gmii_tx_clk_en), 32'h1);

        // 10M: 25/25 TXC, 100-cycle enable period, nibbles of 8'h96
        txd = 8'h96; en = 1'b1; er = 1'b0; speed = 2'b00;
        tick();
        pulses = 0;
        for (int i = 1; i <= 130; i++) begin
            tick();
            if (mac_gmii_tx_clk_en) pulses++;
            if (i <= 50) begin
                check("t10_txc_d1", 32'(txc_d1), 32'(i <= 25));
                check("t10_txc_d2", 32'(txc_d2), 32'(i <= 25));
            end
            if (i == 27 || i == 76) check("t10_lo", 32'({txd_d1, txd_d2}), 32'h66);
            if (i == 77 || i == 126) check("t10_hi", 32'({txd_d1, txd_d2}), 32'h99);
        end
        check("t10_pulses", 32'(pulses), 32'd2);

        // Async reset mid-cycle at 10M
        #2 rst = 1'b1;
        #1;
        check("async_rst", 32'(dut_vec), 32'h0);
        speed = 2'b10;
        #2 rst = 1'b0;
        model_reset();
        tick();
        check("post_rst_clken", 32'(mac_gmii_tx_clk_en), 32'h1);
        check("post_rst_txd", 32'({txd_d1, txd_d2}), 32'h69);

        // Randomized traffic across speed changes
        for (int s = 0; s < 14; s++) begin
            r = $urandom;
            speed = r[1:0];
            if (s == 3) speed = 2'b00;
            if (s == 6) speed = 2'b01;
            n = speed[1] ? 20 : (speed[0] ? 60 : 230);
            for (int c = 0; c < n; c++) begin
                r   = $urandom;
                txd = r[7:0];
                en  = r[8];
                er  = r[9];
                tick();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
